// File: rtl/bus_reorder_pkg.sv
// Shared types for the bus reorder stage: reorder mode encoding and skid buffer state.
package bus_reorder_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS     = 2'd0,
    MODE_BITREV   = 2'd1,
    MODE_LANESWAP = 2'd2,
    MODE_LANEREV  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/bus_reorder_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready and out_valid come straight from flops.
module bus_reorder_skid
  import bus_reorder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // out_data is the head entry; skid_q only holds a beat while FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_data  <= '0;
      skid_q    <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (in_xfer) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state    <= ST_FULL;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            out_data <= skid_q;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_reorder_pipe.sv
// Registered bus bit-order converter: per-beat reorder wiring in front of a skid buffer, plus a transfer counter.
module bus_reorder_pipe
  import bus_reorder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int unsigned LANE_S = (LANE == 0) ? 1 : LANE;
  localparam int unsigned LANES  = WIDTH / LANE_S;

  if (LANE == 0 || (WIDTH % LANE_S) != 0 || WIDTH < LANE_S) begin : g_bad_param
    $error("bus_reorder_pipe: WIDTH must be a non-zero multiple of LANE");
  end

  logic [WIDTH-1:0] bitrev_c;
  logic [WIDTH-1:0] laneswap_c;
  logic [WIDTH-1:0] lanerev_c;
  logic [WIDTH-1:0] reorder_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bitrev
    assign bitrev_c[i] = in_data[WIDTH-1-i];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar j = 0; j < LANE_S; j++) begin : g_bit
      assign laneswap_c[k*LANE_S+j] = in_data[(LANES-1-k)*LANE_S+j];
      assign lanerev_c[k*LANE_S+j]  = in_data[k*LANE_S+LANE_S-1-j];
    end
  end

  // Mode is applied at acceptance, so buffered beats are immune to later mode changes.
  always_comb begin
    reorder_c = in_data;
    case (mode_t'(in_mode))
      MODE_PASS:     reorder_c = in_data;
      MODE_BITREV:   reorder_c = bitrev_c;
      MODE_LANESWAP: reorder_c = laneswap_c;
      MODE_LANEREV:  reorder_c = lanerev_c;
      default:       reorder_c = in_data;
    endcase
  end

  bus_reorder_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (reorder_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_reorder_pipe.sv
// Directed self-checking bench for bus_reorder_pipe (WIDTH=16, LANE=8, CNT_W=16).
module tb_bus_reorder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] xfer_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_reorder_pipe #(
    .WIDTH(16),
    .LANE (8),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_count(xfer_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [15:0] vec_in  [4] = '{16'h1234, 16'h0001, 16'h1234, 16'h0180};
  logic [15:0] vec_exp [4] = '{16'h1234, 16'h8000, 16'h3412, 16'h8001};
  logic [15:0] sw_exp  [4] = '{16'h00FF, 16'hFF00, 16'hFF00, 16'h00FF};

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    in_mode = 2'd0;
    out_ready = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0000);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Per-mode data, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = vec_in[i];
      in_mode = 2'(i);
      step();
      in_valid = 1'b0;
      chk($sformatf("mode%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("mode%0d_data", i), 32'(out_data), 32'(vec_exp[i]));
      step();
      chk($sformatf("mode%0d_drain", i), 32'(out_valid), 32'd0);
    end
    chk("mode_count", 32'(xfer_count), 32'd4);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    in_mode = 2'd0;
    in_valid = 1'b1;
    in_data = 16'hA001;
    step();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    in_data = 16'hA002;
    step();
    chk("bp_ready2", 32'(in_ready), 32'd0);
    chk("bp_head2", 32'(out_data), 32'hA001);
    in_data = 16'hA003;
    repeat (2) step();
    chk("bp_ready_hold", 32'(in_ready), 32'd0);
    chk("bp_head_hold", 32'(out_data), 32'hA001);
    chk("bp_valid_hold", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out2", 32'(out_data), 32'hA002);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out3", 32'(out_data), 32'hA003);
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(xfer_count), 32'd3);

    // Mode switch every beat, back-to-back
    in_valid = 1'b1;
    in_data = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      in_mode = 2'(i);
      step();
      chk($sformatf("sw%0d_data", i), 32'(out_data), 32'(sw_exp[i]));
      chk($sformatf("sw%0d_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("sw_empty", 32'(out_valid), 32'd0);
    chk("sw_count", 32'(xfer_count), 32'd7);

    // Reset while FULL, with out_ready high on the reset edge
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = 2'd0;
    in_data = 16'hB001;
    step();
    in_data = 16'hB002;
    step();
    in_valid = 1'b0;
    chk("mr_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", 32'(out_data), 32'h0000);
    chk("mr_count", 32'(xfer_count), 32'd0);
    repeat (3) step();
    chk("mr_no_emit", 32'(out_valid), 32'd0);
    chk("mr_count_after", 32'(xfer_count), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);

    // Counter wrap: 65535 transfers then one more
    in_valid = 1'b1;
    in_data = 16'h5A5A;
    repeat (65535) step();
    in_valid = 1'b0;
    step();
    chk("wrap_pre_count", 32'(xfer_count), 32'hFFFF);
    chk("wrap_pre_empty", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("wrap_last_valid", 32'(out_valid), 32'd1);
    step();
    chk("wrap_count", 32'(xfer_count), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
